// File: rtl/mcode_seq.sv
// Microcode sequencer: FETCH/EXEC loop driving a 64x27 microcode ROM and forwarding its control vector.
// Optional call/return stack enabled by defining MCODE_STACK_EN (default build: CALL acts as JUMP, RET halts with err).
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | halted; waits for start, a holds its last value
// S_FETCH | ROM latches a; z becomes valid next cycle
// S_EXEC  | evaluate z, strobe ctl on exit; loops here while WAIT's c=0
module mcode_seq #(
  parameter int STACK_DEPTH = 2
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        start,
  input  logic [0:5]  start_addr,
  input  logic [0:7]  cond,
  input  logic [0:26] z,
  output logic [0:5]  a,
  output logic [0:14] ctl,
  output logic        ctl_stb,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC} state_t;

  localparam logic [2:0] OP_NEXT = 3'd0;
  localparam logic [2:0] OP_JUMP = 3'd1;
  localparam logic [2:0] OP_BRT  = 3'd2;
  localparam logic [2:0] OP_BRF  = 3'd3;
  localparam logic [2:0] OP_CALL = 3'd4;
  localparam logic [2:0] OP_RET  = 3'd5;
  localparam logic [2:0] OP_WAIT = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  if (STACK_DEPTH < 1 || STACK_DEPTH > 4) begin : g_bad_depth
    $error("mcode_seq: STACK_DEPTH must be 1..4");
  end

  state_t      state, state_d;
  logic [0:5]  a_d;
  logic [0:14] ctl_d;
  logic        ctl_stb_d, busy_d, done_d, err_d;

  logic [0:5]  tgt;
  logic [2:0]  op;
  logic [2:0]  cs;
  logic        c;
  logic [0:5]  pc_inc;

  assign tgt    = z[0:5];
  assign op     = z[6:8];
  assign cs     = z[9:11];
  assign c      = cond[cs];
  assign pc_inc = a + 6'd1;

`ifdef MCODE_STACK_EN
  logic [2:0]  sp;
  logic [0:5]  stk [STACK_DEPTH];
  logic [0:5]  stack_top;
  logic        stack_full, stack_empty;
  logic        push, pop;

  assign stack_full  = (int'(sp) == STACK_DEPTH);
  assign stack_empty = (sp == 3'd0);

  always_comb begin
    stack_top = '0;
    for (int i = 0; i < STACK_DEPTH; i++)
      if (i == int'(sp) - 1) stack_top = stk[i];
  end

  // A push onto a full stack shifts out the oldest return address.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      sp <= 3'd0;
    end else if (push) begin
      if (stack_full) begin
        for (int i = 0; i < STACK_DEPTH - 1; i++) stk[i] <= stk[i+1];
        stk[STACK_DEPTH-1] <= pc_inc;
      end else begin
        for (int i = 0; i < STACK_DEPTH; i++)
          if (i == int'(sp)) stk[i] <= pc_inc;
        sp <= sp + 3'd1;
      end
    end else if (pop && !stack_empty) begin
      sp <= sp - 3'd1;
    end
  end
`endif

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state   <= S_IDLE;
      a       <= '0;
      ctl     <= '0;
      ctl_stb <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_d;
      a       <= a_d;
      ctl     <= ctl_d;
      ctl_stb <= ctl_stb_d;
      busy    <= busy_d;
      done    <= done_d;
      err     <= err_d;
    end
  end

  always_comb begin
    state_d   = state;
    a_d       = a;
    ctl_d     = ctl;
    ctl_stb_d = 1'b0;
    busy_d    = busy;
    done_d    = 1'b0;
    err_d     = err;
`ifdef MCODE_STACK_EN
    push      = 1'b0;
    pop       = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          a_d     = start_addr;
          err_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        state_d   = S_FETCH;
        ctl_d     = z[12:26];
        ctl_stb_d = 1'b1;
        case (op)
          OP_NEXT: a_d = pc_inc;
          OP_JUMP: a_d = tgt;
          OP_BRT:  a_d = c ? tgt : pc_inc;
          OP_BRF:  a_d = c ? pc_inc : tgt;
          OP_CALL: begin
`ifdef MCODE_STACK_EN
            push = 1'b1;
            if (stack_full) err_d = 1'b1;
`endif
            a_d = tgt;
          end
          OP_RET: begin
`ifdef MCODE_STACK_EN
            pop = 1'b1;
            if (stack_empty) begin
              a_d   = '0;
              err_d = 1'b1;
            end else begin
              a_d = stack_top;
            end
`else
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            err_d   = 1'b1;
`endif
          end
          OP_WAIT: begin
            if (c) begin
              a_d = pc_inc;
            end else begin
              state_d   = S_EXEC;
              ctl_d     = ctl;
              ctl_stb_d = 1'b0;
            end
          end
          default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mcode_seq.sv
// Scoreboard bench for mcode_seq: stimulus pushes expected strobes, a negedge monitor pops and compares.
// Stack expectations switch with MCODE_STACK_EN.
module tb_mcode_seq;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        start;
  logic [0:5]  start_addr;
  logic [0:7]  cond;
  logic [0:26] z;
  logic [0:5]  a;
  logic [0:14] ctl;
  logic        ctl_stb, busy, done, err;

  logic [0:26] rom [64];

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [0:14] ctl;
    logic [0:5]  a;
    logic        d;
  } exp_t;
  exp_t q[$];

  mcode_seq #(.STACK_DEPTH(2)) dut (
    .sys_clk(sys_clk), .reset(reset), .start(start), .start_addr(start_addr),
    .cond(cond), .z(z), .a(a), .ctl(ctl), .ctl_stb(ctl_stb),
    .busy(busy), .done(done), .err(err)
  );

  always #5 sys_clk = ~sys_clk;

  always_ff @(posedge sys_clk) z <= rom[a];

  function automatic logic [0:26] mk(input logic [5:0] tgt, input logic [2:0] op,
                                     input logic [2:0] cs, input logic [5:0] addr);
    logic [14:0] cv;
    cv = 15'h100 + {9'd0, addr};
    return {tgt, op, cs, cv};
  endfunction

  task automatic expect_stb(input logic [5:0] word_addr, input logic [5:0] next_a, input logic d);
    exp_t e;
    e.ctl = 15'h100 + {9'd0, word_addr};
    e.a   = next_a;
    e.d   = d;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, expv);
    end
  endtask

  always @(negedge sys_clk) begin
    exp_t e;
    if (!reset && ctl_stb) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected ctl=%0h a=%0d", ctl, a);
      end else begin
        e = q.pop_front();
        if (ctl !== e.ctl || a !== e.a || done !== e.d || busy !== !e.d) begin
          errors++;
          $display("FAIL strobe ctl=%0h/%0h a=%0d/%0d done=%0b/%0b busy=%0b (got/expected)",
                   ctl, e.ctl, a, e.a, done, e.d, busy);
        end
      end
    end
  end

  // Start a program, check the FETCH cycle, then wait (bounded) for done.
  task automatic run(input string name, input logic [5:0] sa, input int exp_cyc);
    int cyc;
    start = 1'b1;
    start_addr = sa;
    @(posedge sys_clk);
    #1 start = 1'b0;
    @(negedge sys_clk);
    chk({name, "_fetch_a"}, int'(a), int'(sa));
    chk({name, "_fetch_busy_err"}, int'({busy, err}), 2);
    cyc = 1;
    while (!done && cyc < 64) begin
      @(negedge sys_clk);
      cyc++;
    end
    chk({name, "_cycles_to_done"}, cyc, exp_cyc);
    #1;
    chk({name, "_queue_drained"}, q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 64; k++) rom[k] = mk(6'd0, 3'd7, 3'd0, 6'(k));
    rom[5]  = mk(6'd0,  3'd0, 3'd0, 6'd5);
    rom[6]  = mk(6'd0,  3'd0, 3'd0, 6'd6);
    rom[10] = mk(6'd40, 3'd2, 3'd3, 6'd10);
    rom[12] = mk(6'd40, 3'd3, 3'd3, 6'd12);
    rom[20] = mk(6'd0,  3'd6, 3'd0, 6'd20);
    rom[63] = mk(6'd0,  3'd0, 3'd0, 6'd63);
    rom[30] = mk(6'd33, 3'd4, 3'd0, 6'd30);
    rom[33] = mk(6'd36, 3'd4, 3'd0, 6'd33);
    rom[34] = mk(6'd0,  3'd5, 3'd0, 6'd34);
    rom[36] = mk(6'd0,  3'd5, 3'd0, 6'd36);
    rom[44] = mk(6'd45, 3'd4, 3'd0, 6'd44);
    rom[45] = mk(6'd46, 3'd4, 3'd0, 6'd45);
    rom[46] = mk(6'd47, 3'd4, 3'd0, 6'd46);
    rom[50] = mk(6'd0,  3'd5, 3'd0, 6'd50);

    reset = 1'b1;
    start = 1'b0;
    start_addr = '0;
    cond = '0;
    repeat (3) @(negedge sys_clk);
    chk("reset_outputs", int'({a, ctl, ctl_stb, busy, done, err}), 0);
    start = 1'b1;
    start_addr = 6'd5;
    @(negedge sys_clk);
    chk("reset_beats_start", int'({a, busy}), 0);
    start = 1'b0;
    reset = 1'b0;

    // Sequential run 5,6,7.
    expect_stb(6'd5, 6'd6, 1'b0);
    expect_stb(6'd6, 6'd7, 1'b0);
    expect_stb(6'd7, 6'd7, 1'b1);
    run("seq", 6'd5, 7);

    // BRT/BRF on cond[3], other bits set opposite.
    cond = '0; cond[3] = 1'b1;
    expect_stb(6'd10, 6'd40, 1'b0);
    expect_stb(6'd40, 6'd40, 1'b1);
    run("brt_taken", 6'd10, 5);
    cond = '1; cond[3] = 1'b0;
    expect_stb(6'd10, 6'd11, 1'b0);
    expect_stb(6'd11, 6'd11, 1'b1);
    run("brt_fall", 6'd10, 5);
    cond = '0; cond[3] = 1'b1;
    expect_stb(6'd12, 6'd13, 1'b0);
    expect_stb(6'd13, 6'd13, 1'b1);
    run("brf_fall", 6'd12, 5);
    cond = '1; cond[3] = 1'b0;
    expect_stb(6'd12, 6'd40, 1'b0);
    expect_stb(6'd40, 6'd40, 1'b1);
    run("brf_taken", 6'd12, 5);

    // WAIT: cond[0] pulses high only during FETCH, then low 5 EXEC cycles, then high.
    cond = '0;
    expect_stb(6'd20, 6'd21, 1'b0);
    expect_stb(6'd21, 6'd21, 1'b1);
    fork
      run("wait", 6'd20, 10);
      begin
        @(posedge sys_clk);
        #1 cond[0] = 1'b1;
        @(posedge sys_clk);
        #1 cond[0] = 1'b0;
        repeat (5) @(posedge sys_clk);
        #1 cond[0] = 1'b1;
      end
    join
    cond = '0;

    // Wrap 63 -> 0, with a start pulse while busy.
    expect_stb(6'd63, 6'd0, 1'b0);
    expect_stb(6'd0,  6'd0, 1'b1);
    fork
      run("wrap", 6'd63, 5);
      begin
        @(posedge sys_clk);
        @(negedge sys_clk);
        start = 1'b1;
        start_addr = 6'd30;
        @(posedge sys_clk);
        #1 start = 1'b0;
      end
    join

`ifdef MCODE_STACK_EN
    expect_stb(6'd30, 6'd33, 1'b0);
    expect_stb(6'd33, 6'd36, 1'b0);
    expect_stb(6'd36, 6'd34, 1'b0);
    expect_stb(6'd34, 6'd31, 1'b0);
    expect_stb(6'd31, 6'd31, 1'b1);
    run("nested_call", 6'd30, 11);
    chk("nested_call_err", int'(err), 0);
`else
    expect_stb(6'd30, 6'd33, 1'b0);
    expect_stb(6'd33, 6'd36, 1'b0);
    expect_stb(6'd36, 6'd36, 1'b1);
    run("call_as_jump", 6'd30, 7);
    chk("ret_halt_err", int'(err), 1);
`endif

    expect_stb(6'd44, 6'd45, 1'b0);
    expect_stb(6'd45, 6'd46, 1'b0);
    expect_stb(6'd46, 6'd47, 1'b0);
    expect_stb(6'd47, 6'd47, 1'b1);
    run("triple_call", 6'd44, 9);
`ifdef MCODE_STACK_EN
    chk("overflow_err", int'(err), 1);
`else
    chk("triple_call_err", int'(err), 0);
`endif

    // Reset during EXEC of the CALL at 30.
    start = 1'b1;
    start_addr = 6'd30;
    @(posedge sys_clk);
    #1 start = 1'b0;
    @(posedge sys_clk);
    #1 reset = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    chk("midrun_reset_outputs", int'({a, ctl, ctl_stb, busy, done, err}), 0);
    reset = 1'b0;
    @(negedge sys_clk);

`ifdef MCODE_STACK_EN
    expect_stb(6'd50, 6'd0, 1'b0);
    expect_stb(6'd0,  6'd0, 1'b1);
    run("ret_empty", 6'd50, 5);
`else
    expect_stb(6'd50, 6'd50, 1'b1);
    run("ret_nostack", 6'd50, 3);
`endif
    chk("ret_err", int'(err), 1);

    repeat (3) @(negedge sys_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcode_seq.md
# mcode_seq

Microcode sequencer that drives the 6-bit address of the 64×27 microcode ROM and consumes the registered word it returns. It executes one microinstruction every two `sys_clk` cycles: a FETCH cycle covers the ROM's one-cycle read latency, and an EXEC cycle evaluates the word. Each microinstruction provides next-address control (sequential, jump, conditional branch, call/return, wait, halt) and a 15-bit control vector that the sequencer forwards to the datapath.

## Interface
Parameters:
- `STACK_DEPTH`, default 2: number of call/return stack entries, range 1–4. Only meaningful with `MCODE_STACK_EN`.

Ports:
- `sys_clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin execution at `start_addr`. Sampled only in IDLE.
- `start_addr`  in  [0:5]  entry address.
- `cond`  in  [0:7]  condition inputs, selected by the word's condition field.
- `z`  in  [0:26]  microcode word from the ROM. Valid one cycle after `a` changes.
- `a`  out  [0:5]  ROM address, registered.
- `ctl`  out  [0:14]  control vector, registered copy of `z[12:26]`.
- `ctl_stb`  out  1  one-cycle strobe: `ctl` is new.
- `busy`  out  1  high from FETCH of the first word until halt.
- `done`  out  1  one-cycle pulse on halt.
- `err`  out  1  sticky stack fault. Cleared by `reset` or by an accepted `start`.

## Operation
Word fields (`z[0]` is the MSB side):
- `z[0:5]`: target address.
- `z[6:8]`: op.
- `z[9:11]`: condition select `cs`; the selected condition is `c = cond[cs]`.
- `z[12:26]`: control vector.

States:
- IDLE → FETCH on `start`. Loads `a <= start_addr` and clears `err`.
- FETCH → EXEC unconditionally. The ROM latches `a` during this cycle.
- EXEC: evaluates `z` as described below. It then returns to FETCH with the new `a`, stays in EXEC (WAIT), or goes to IDLE (HALT).

Ops in EXEC (`pc` is the current `a`; `pc+1` is modulo 64, so 63+1 = 0):
- 0 NEXT: `a <= pc+1`.
- 1 JUMP: `a <= target`.
- 2 BRT: `a <= c ? target : pc+1`.
- 3 BRF: `a <= c ? pc+1 : target`.
- 4 CALL: push `pc+1`, then `a <= target`.
- 5 RET: pop into `a`.
- 6 WAIT:
  - `c`=0: stay in EXEC with `a` unchanged; `z` stays stable and no strobe is issued.
  - `c`=1: `a <= pc+1` and go to FETCH.
- 7 HALT: go to IDLE, `done` pulses, `busy` goes low, `a` holds.

Control vector:
- `ctl <= z[12:26]` and `ctl_stb <= 1` on every EXEC cycle that leaves EXEC, including HALT and a WAIT that completes.
- `ctl` holds its value between strobes.

Stack faults:
- CALL with the stack full: the oldest entry is dropped, the push proceeds, `err` is set.
- RET with the stack empty: `a <= 0`, `err` is set, execution continues.

Boundary cases:
- `start` while busy is ignored.
- `reset` overrides everything, including `start` in the same cycle and any operation in progress.
- A `cond` change during FETCH has no effect; `cond` is sampled only in EXEC.

## Timing
Reset values: state IDLE, `a`=0, `ctl`=0, `ctl_stb`=0, `busy`=0, `done`=0, `err`=0, stack pointer 0.

Start sequence, with `start` high at cycle n:
- n+1: `a` = `start_addr`, FETCH, `busy`=1.
- n+2: `z` valid, EXEC.
- n+3: `ctl` and `ctl_stb` visible, next `a` visible, FETCH.

Throughput and latency:
- Steady state: one microinstruction per 2 cycles, `ctl_stb` high every other cycle.
- WAIT adds one cycle per EXEC cycle with `c`=0.
- `done` is high in the cycle after HALT's EXEC, coinciding with `busy`=0 and the final `ctl_stb`.
- `start` can be accepted again in that same cycle.

## Configuration
`MCODE_STACK_EN`:
- Defined: the call/return stack of `STACK_DEPTH` entries is built, and CALL and RET behave as described above.
- Undefined: no stack storage. CALL behaves as JUMP. RET behaves as HALT and additionally sets `err`.

## Test plan
- Sequential run: ROM words 5–7 = NEXT, NEXT, HALT, `start_addr`=5 → `a` = 5, 6, 7 on alternate cycles; three `ctl_stb` pulses; `done` 7 cycles after `start`.
- Branching: BRT at address 10 with `cs`=3, target 40.
  - `cond[3]`=1 → next `a`=40.
  - `cond[3]`=0 → next `a`=11.
  - Repeat with BRF and check the opposite results.
- Wait: WAIT with `cs`=0, `cond[0]` held low for 5 cycles then high → EXEC held for 6 cycles, a single `ctl_stb`, then `a` = `pc`+1.
- Stack (`STACK_DEPTH`=2, macro defined): nested CALL 2 deep then RET, RET → returns to the correct addresses, `err`=0. A third nested CALL → `err`=1. RET on an empty stack → `a`=0.
- Wrap and ignore: NEXT at 63 → `a`=0. `start` pulsed while busy → no change to `a` or state.
- Reset mid-run: assert `reset` during EXEC of a CALL → next cycle all outputs at reset values and stack empty. With the macro undefined, RET → `done` and `err`=1.
